// File: rtl/gf16_arb_pkg.sv
// Shared constants and FSM state encodings for the GF(2^16) resource arbiter.
package gf16_arb_pkg;

    localparam int W       = 16;
    localparam int LANES   = 9;
    localparam int INV_LAT = 17;
    localparam int CNT_W   = $clog2(INV_LAT + 1);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_OWN  = 2'd1,
        M_GAP  = 2'd2
    } mul_state_t;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_OWN  = 2'd1,
        I_BUSY = 2'd2,
        I_DONE = 2'd3
    } inv_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// otherwise lowest requesting index overall. Grant is one-hot or zero.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic hit;

    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && req[i] && (i >= int'(ptr))) begin
                hit    = 1'b1;
                gnt[i] = 1'b1;
                idx    = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && req[i]) begin
                hit    = 1'b1;
                gnt[i] = 1'b1;
                idx    = PW'(i);
            end
        end
    end

endmodule

// File: rtl/gf16_resource_arbiter.sv
// Shares the multiplier array (burst ownership) and the inverter
// (transaction ownership) between NREQ requesters, one round-robin channel each.
//
// multiplier FSM
//   state  | meaning
//   M_IDLE | no owner; grant registered on any request
//   M_OWN  | owner's operands muxed onto the array
//   M_GAP  | one dead cycle so the last result is not seen by the next owner
//
// inverter FSM
//   state  | meaning
//   I_IDLE | no owner
//   I_OWN  | owner granted, waiting for its trigger
//   I_BUSY | operand latched, counting to INV_LAT
//   I_DONE | result latched; re-own or release
module gf16_resource_arbiter
    import gf16_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic [NREQ-1:0]         mul_req,
    input  logic [NREQ*LANES*W-1:0] mul_o_in,
    input  logic [NREQ*W-1:0]       mul_t_in,
    output logic [NREQ-1:0]         mul_gnt,
    output logic [LANES*W-1:0]      mul_r_out,
    input  logic [NREQ-1:0]         inv_req,
    input  logic [NREQ*W-1:0]       inv_in,
    input  logic [NREQ-1:0]         inv_trg_in,
    output logic [NREQ-1:0]         inv_gnt,
    output logic [NREQ-1:0]         inv_done,
    output logic [W-1:0]            inv_r_out,
    output logic                    inv_err,
    output logic [LANES*W-1:0]      mul_o_out,
    output logic [W-1:0]            mul_t_out,
    input  logic [LANES*W-1:0]      mul_r_in,
    output logic [W-1:0]            inv_out,
    output logic                    inv_en,
    output logic                    inv_trg,
    input  logic [W-1:0]            inv_r_in
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    mul_state_t        m_state, m_next;
    logic [NREQ-1:0]   m_gnt_q, m_gnt_d, m_arb_gnt;
    logic [PW-1:0]     m_ptr_q, m_ptr_d, m_arb_idx;
    logic [LANES*W-1:0] m_sel_o;
    logic [W-1:0]      m_sel_t;
    logic              m_owner_req;

    inv_state_t        i_state, i_next;
    logic [NREQ-1:0]   i_gnt_q, i_gnt_d, i_arb_gnt;
    logic [PW-1:0]     i_ptr_q, i_ptr_d, i_arb_idx;
    logic [W-1:0]      i_own_in;
    logic              i_owner_req, i_owner_trg;
    logic [NREQ-1:0]   honour_mask;
    logic [W-1:0]      op_q, op_d, r_q, r_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trg_q, trg_d, err_q, err_d;
    logic [NREQ-1:0]   done_q, done_d;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_mul_arb (
        .req (mul_req),
        .ptr (m_ptr_q),
        .gnt (m_arb_gnt),
        .idx (m_arb_idx)
    );

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_inv_arb (
        .req (inv_req),
        .ptr (i_ptr_q),
        .gnt (i_arb_gnt),
        .idx (i_arb_idx)
    );

    // Grants are one-hot, so masking with the grant selects the owner.
    assign m_owner_req = |(mul_req & m_gnt_q);
    assign i_owner_req = |(inv_req & i_gnt_q);
    assign i_owner_trg = |(inv_trg_in & i_gnt_q);

    always_comb begin
        m_sel_o  = '0;
        m_sel_t  = '0;
        i_own_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (m_gnt_q[i]) begin
                m_sel_o = mul_o_in[i*LANES*W +: LANES*W];
                m_sel_t = mul_t_in[i*W +: W];
            end
            if (i_gnt_q[i]) begin
                i_own_in = inv_in[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_state <= M_IDLE;
            m_gnt_q <= '0;
            m_ptr_q <= '0;
        end else begin
            m_state <= m_next;
            m_gnt_q <= m_gnt_d;
            m_ptr_q <= m_ptr_d;
        end
    end

    always_comb begin
        m_next  = m_state;
        m_gnt_d = m_gnt_q;
        m_ptr_d = m_ptr_q;
        case (m_state)
            M_IDLE: begin
                if (|mul_req) begin
                    m_next  = M_OWN;
                    m_gnt_d = m_arb_gnt;
                    m_ptr_d = rr_next(m_arb_idx);
                end
            end
            M_OWN: begin
                if (!m_owner_req) begin
                    m_next  = M_GAP;
                    m_gnt_d = '0;
                end
            end
            M_GAP: m_next = M_IDLE;
            default: begin
                m_next  = M_IDLE;
                m_gnt_d = '0;
            end
        endcase
    end

    assign mul_gnt   = m_gnt_q;
    assign mul_o_out = (m_state == M_OWN) ? m_sel_o : '0;
    assign mul_t_out = (m_state == M_OWN) ? m_sel_t : '0;
    assign mul_r_out = mul_r_in;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            i_state <= I_IDLE;
            i_gnt_q <= '0;
            i_ptr_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            trg_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= '0;
            r_q     <= '0;
        end else begin
            i_state <= i_next;
            i_gnt_q <= i_gnt_d;
            i_ptr_q <= i_ptr_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            trg_q   <= trg_d;
            err_q   <= err_d;
            done_q  <= done_d;
            r_q     <= r_d;
        end
    end

    // Only the owner's trigger while in I_OWN starts a transaction.
    assign honour_mask = (i_state == I_OWN) ? i_gnt_q : '0;

    always_comb begin
        i_next  = i_state;
        i_gnt_d = i_gnt_q;
        i_ptr_d = i_ptr_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        trg_d   = 1'b0;
        done_d  = '0;
        r_d     = r_q;
        err_d   = |(inv_trg_in & ~honour_mask);
        case (i_state)
            I_IDLE: begin
                if (|inv_req) begin
                    i_next  = I_OWN;
                    i_gnt_d = i_arb_gnt;
                    i_ptr_d = rr_next(i_arb_idx);
                end
            end
            I_OWN: begin
                if (i_owner_trg) begin
                    i_next = I_BUSY;
                    trg_d  = 1'b1;
                    op_d   = i_own_in;
                    cnt_d  = '0;
                end else if (!i_owner_req) begin
                    i_next  = I_IDLE;
                    i_gnt_d = '0;
                end
            end
            I_BUSY: begin
                if (cnt_q == CNT_W'(INV_LAT)) begin
                    i_next = I_DONE;
                    r_d    = inv_r_in;
                    done_d = i_gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            I_DONE: begin
                if (i_owner_req) begin
                    i_next = I_OWN;
                end else begin
                    i_next  = I_IDLE;
                    i_gnt_d = '0;
                end
            end
            default: begin
                i_next  = I_IDLE;
                i_gnt_d = '0;
            end
        endcase
    end

    assign inv_gnt   = i_gnt_q;
    assign inv_done  = done_q;
    assign inv_r_out = r_q;
    assign inv_err   = err_q;
    assign inv_trg   = trg_q;
    assign inv_en    = (i_state != I_IDLE);
    assign inv_out   = (i_state == I_OWN) ? i_own_in :
                       (i_state == I_IDLE) ? '0 : op_q;

endmodule

// File: tb/tb_gf16_resource_arbiter.sv
// Directed bench for gf16_resource_arbiter with behavioural multiplier and
// inverter models and a queue of expected results.
module tb_gf16_resource_arbiter;
    import gf16_arb_pkg::*;

    localparam int NREQ = 2;
    localparam logic [143:0] OP_A = 144'h1009_1008_1007_1006_1005_1004_1003_1002_1001;
    localparam logic [143:0] OP_B = 144'h2009_2008_2007_2006_2005_2004_2003_2002_2001;
    localparam logic [143:0] OP_C = 144'h3a39_3a38_3a37_3a36_3a35_3a34_3a33_3a32_3a31;

    logic                    clk = 1'b0;
    logic                    rst_b = 1'b0;
    logic [NREQ-1:0]         mul_req = '0;
    logic [NREQ*LANES*W-1:0] mul_o_in = '0;
    logic [NREQ*W-1:0]       mul_t_in = '0;
    logic [NREQ-1:0]         mul_gnt;
    logic [LANES*W-1:0]      mul_r_out;
    logic [NREQ-1:0]         inv_req = '0;
    logic [NREQ*W-1:0]       inv_in = '0;
    logic [NREQ-1:0]         inv_trg_in = '0;
    logic [NREQ-1:0]         inv_gnt;
    logic [NREQ-1:0]         inv_done;
    logic [W-1:0]            inv_r_out;
    logic                    inv_err;
    logic [LANES*W-1:0]      mul_o_out;
    logic [W-1:0]            mul_t_out;
    logic [LANES*W-1:0]      mul_r_in = '0;
    logic [W-1:0]            inv_out;
    logic                    inv_en;
    logic                    inv_trg;
    logic [W-1:0]            inv_r_in = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_trg = 0;
    int trg_count = 0;
    int m_cnt = 0;
    logic [W-1:0] m_op = '0;
    logic [143:0] mr_tmp;
    logic done_seen;

    typedef struct {
        string        tag;
        logic [143:0] val;
    } sb_t;
    sb_t sb[$];

    gf16_resource_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .mul_req    (mul_req),
        .mul_o_in   (mul_o_in),
        .mul_t_in   (mul_t_in),
        .mul_gnt    (mul_gnt),
        .mul_r_out  (mul_r_out),
        .inv_req    (inv_req),
        .inv_in     (inv_in),
        .inv_trg_in (inv_trg_in),
        .inv_gnt    (inv_gnt),
        .inv_done   (inv_done),
        .inv_r_out  (inv_r_out),
        .inv_err    (inv_err),
        .mul_o_out  (mul_o_out),
        .mul_t_out  (mul_t_out),
        .mul_r_in   (mul_r_in),
        .inv_out    (inv_out),
        .inv_en     (inv_en),
        .inv_trg    (inv_trg),
        .inv_r_in   (inv_r_in)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // GF(2^16) with x^16 + x^12 + x^3 + x + 1
    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[14:0], 1'b0} ^ (x[15] ? 16'h100b : 16'h0000);
        end
        return p;
    endfunction

    function automatic logic [15:0] gf_inv(input logic [15:0] a);
        logic [15:0] r;
        r = '0;
        for (int x = 1; x < 65536; x++) begin
            if (gf_mul(a, 16'(x)) == 16'h0001) begin
                r = 16'(x);
                break;
            end
        end
        return r;
    endfunction

    // MUL_ARRAY model: one-cycle registered lane-wise product
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            mr_tmp[l*16 +: 16] = gf_mul(mul_o_out[l*16 +: 16], mul_t_out);
        mul_r_in <= mr_tmp;
    end

    // INV_GENERATOR model: result valid INV_LAT cycles after inv_trg
    always @(posedge clk) begin
        if (inv_trg === 1'b1) begin
            trg_count++;
            m_op = inv_out;
            m_cnt = 1;
            inv_r_in <= 16'hdead;
        end else if (m_cnt != 0) begin
            m_cnt++;
            if (m_cnt == INV_LAT) inv_r_in <= gf_inv(m_op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [143:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [143:0] obs);
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed=%0h expected=queued_entry", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (inv_done == '0 && n < 40);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_mul_gnt",   144'(mul_gnt),   '0);
        chk("rst_inv_gnt",   144'(inv_gnt),   '0);
        chk("rst_inv_done",  144'(inv_done),  '0);
        chk("rst_inv_err",   144'(inv_err),   '0);
        chk("rst_inv_en",    144'(inv_en),    '0);
        chk("rst_inv_trg",   144'(inv_trg),   '0);
        chk("rst_inv_r_out", 144'(inv_r_out), '0);
        chk("rst_mul_o_out", 144'(mul_o_out), '0);
        rst_b = 1'b1;

        // single multiplier requester
        mul_o_in = {OP_B, OP_A};
        mul_t_in = {16'h0001, 16'h0001};
        mul_req  = 2'b01;
        tick();
        chk("mul_gnt_single", 144'(mul_gnt), 144'(2'b01));
        chk("mul_o_owner0",   144'(mul_o_out), OP_A);
        chk("mul_t_owner0",   144'(mul_t_out), 144'(16'h0001));
        sb_push("mul_r_a", OP_A);
        tick();
        sb_pop(144'(mul_r_out));
        mul_o_in[143:0] = OP_C;
        mul_t_in[15:0]  = 16'h0000;
        #1;
        chk("mul_o_update", 144'(mul_o_out), OP_C);
        sb_push("mul_r_zero", '0);
        tick();
        sb_pop(144'(mul_r_out));
        mul_req = 2'b00;
        tick();
        chk("mul_gnt_release", 144'(mul_gnt), '0);
        chk("mul_o_gap",       144'(mul_o_out), '0);
        mul_req = 2'b10;
        tick();
        chk("mul_gap_one_cycle", 144'(mul_gnt), '0);
        tick();
        chk("mul_gnt_req1", 144'(mul_gnt), 144'(2'b10));
        chk("mul_o_owner1", 144'(mul_o_out), OP_B);
        sb_push("mul_r_b", OP_B);
        tick();
        sb_pop(144'(mul_r_out));
        mul_req = 2'b00;
        tick();
        tick();

        // simultaneous requests after reset
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        mul_req = 2'b11;
        tick();
        chk("mul_rr_first", 144'(mul_gnt), 144'(2'b01));
        mul_req = 2'b10;
        tick();
        chk("mul_rr_gap", 144'(mul_gnt), '0);
        tick();
        tick();
        chk("mul_rr_second", 144'(mul_gnt), 144'(2'b10));
        mul_req = 2'b00;
        tick();
        mul_req = 2'b11;
        tick();
        tick();
        chk("mul_rr_wrap", 144'(mul_gnt), 144'(2'b01));
        tick();
        chk("mul_no_preempt", 144'(mul_gnt), 144'(2'b01));
        mul_req = 2'b00;
        tick();
        tick();

        // inverter transaction from requester 1
        inv_in  = {16'h0002, 16'h0001};
        inv_req = 2'b10;
        tick();
        chk("inv_gnt_req1", 144'(inv_gnt), 144'(2'b10));
        chk("inv_en_own",   144'(inv_en),  144'(1'b1));
        chk("inv_out_own",  144'(inv_out), 144'(16'h0002));
        inv_trg_in = 2'b10;
        tick();
        inv_trg_in = 2'b00;
        t_trg = cyc;
        sb_push("inv_r_first", 144'(16'h8805));
        sb_push("inv_done_first", 144'(2'b10));
        inv_in[31:16] = 16'h1234;
        #1;
        chk("inv_trg_pulse",   144'(inv_trg), 144'(1'b1));
        chk("inv_out_latched", 144'(inv_out), 144'(16'h0002));
        inv_req    = 2'b11;
        inv_trg_in = 2'b01;
        tick();
        inv_trg_in = 2'b00;
        chk("inv_trg_single",   144'(inv_trg), '0);
        chk("inv_err_nonowner", 144'(inv_err), 144'(1'b1));
        tick();
        chk("inv_err_clear", 144'(inv_err), '0);
        inv_trg_in = 2'b10;
        tick();
        inv_trg_in = 2'b00;
        chk("inv_err_busy_owner", 144'(inv_err), 144'(1'b1));
        chk("inv_trg_busy_owner", 144'(inv_trg), '0);
        wait_done();
        chk("inv_done_latency1", 144'(cyc - t_trg), 144'(INV_LAT + 1));
        sb_pop(144'(inv_r_out));
        sb_pop(144'(inv_done));
        chk("inv_trg_count", 144'(trg_count), 144'(1));
        tick();
        chk("inv_done_one_cycle", 144'(inv_done), '0);
        chk("inv_gnt_backtoback", 144'(inv_gnt), 144'(2'b10));
        chk("inv_r_held",         144'(inv_r_out), 144'(16'h8805));
        inv_req = 2'b01;
        tick();
        chk("inv_gnt_drop", 144'(inv_gnt), '0);
        chk("inv_en_drop",  144'(inv_en),  '0);
        tick();
        chk("inv_gnt_req0", 144'(inv_gnt), 144'(2'b01));

        // owner drops its request while BUSY
        inv_trg_in = 2'b01;
        tick();
        inv_trg_in = 2'b00;
        t_trg = cyc;
        inv_req = 2'b00;
        sb_push("inv_r_second", 144'(16'h0001));
        sb_push("inv_done_second", 144'(2'b01));
        chk("inv_trg_pulse2", 144'(inv_trg), 144'(1'b1));
        wait_done();
        chk("inv_done_latency2", 144'(cyc - t_trg), 144'(INV_LAT + 1));
        sb_pop(144'(inv_r_out));
        sb_pop(144'(inv_done));
        tick();
        chk("inv_gnt_release_busy", 144'(inv_gnt), '0);
        chk("inv_en_release_busy",  144'(inv_en),  '0);

        // asynchronous reset in the middle of BUSY
        inv_req = 2'b10;
        tick();
        chk("inv_gnt_pre_rst", 144'(inv_gnt), 144'(2'b10));
        inv_trg_in = 2'b10;
        tick();
        inv_trg_in = 2'b00;
        repeat (5) tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_inv_gnt",   144'(inv_gnt),   '0);
        chk("arst_inv_en",    144'(inv_en),    '0);
        chk("arst_inv_out",   144'(inv_out),   '0);
        chk("arst_inv_r_out", 144'(inv_r_out), '0);
        chk("arst_inv_trg",   144'(inv_trg),   '0);
        tick();
        rst_b = 1'b1;
        tick();
        chk("inv_gnt_after_rst", 144'(inv_gnt), 144'(2'b10));
        done_seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (inv_done != '0) done_seen = 1'b1;
        end
        chk("no_done_after_rst", 144'(done_seen), '0);
        inv_req = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
